brick_wall: RTL

// Holds the Breakout brick field: a ROWS x COLS alive-bitmap, a per-frame collision scan

---
 rtl/brick_wall.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/brick_wall.sv
// Breakout brick field: alive bitmap, registered per-pixel brick lookup for the colour mux,
// and a once-per-frame scan that removes the first alive brick touched by the ball.
module brick_wall #(
    parameter int ROWS    = 4,
    parameter int COLS    = 8,
    parameter int BRICK_W = 64,
    parameter int BRICK_H = 16,
    parameter int LEFT_X  = 64,
    parameter int TOP_Y   = 48,
    parameter int R_BALL  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic       frame_tick,
    input  logic       refill,
    output logic       brick_pixel,
    output logic [2:0] brick_row,
    output logic       hit_brick,
    output logic       bounce_y,
    output logic [7:0] bricks_left,
    output logic       cleared
);

    localparam int NUM     = ROWS * COLS;
    localparam int IDX_W   = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int SHIFT_X = $clog2(BRICK_W);
    localparam int SHIFT_Y = $clog2(BRICK_H);
    localparam int FIELD_W = COLS * BRICK_W;
    localparam int FIELD_H = ROWS * BRICK_H;

    localparam logic [NUM-1:0] ALL_ALIVE  = {NUM{1'b1}};
    localparam logic [7:0]     FULL_COUNT = 8'(NUM);

    localparam logic signed [11:0] RAD     = 12'(R_BALL);
    localparam logic signed [11:0] PITCH_W = 12'(BRICK_W);
    localparam logic signed [11:0] PITCH_H = 12'(BRICK_H);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [NUM-1:0]   alive;
    logic [1:0]       state;
    logic [IDX_W-1:0] scan_idx;
    logic [4:0]       scan_col;
    logic [3:0]       scan_row;
    logic [9:0]       ball_x_q;
    logic [9:0]       ball_y_q;

    // Pixel lookup: range checks happen on the raw coordinate so pixels left of or
    // above the field can never wrap into a valid column/row after the subtraction.
    logic [10:0]      px, py, dx, dy, pix_col, pix_row;
    logic [IDX_W-1:0] pix_idx;
    logic             in_field, on_gap, pixel_next;
    logic [2:0]       row_next;

    assign px       = {1'b0, next_x};
    assign py       = {1'b0, next_y};
    assign in_field = (px >= 11'(LEFT_X)) && (px < 11'(LEFT_X + FIELD_W)) &&
                      (py >= 11'(TOP_Y))  && (py < 11'(TOP_Y + FIELD_H));
    assign dx       = px - 11'(LEFT_X);
    assign dy       = py - 11'(TOP_Y);
    assign pix_col  = dx >> SHIFT_X;
    assign pix_row  = dy >> SHIFT_Y;
    assign pix_idx  = IDX_W'(pix_row * 11'(COLS) + pix_col);
    assign on_gap   = ((dx & 11'(BRICK_W - 1)) == 11'(BRICK_W - 1)) ||
                      ((dy & 11'(BRICK_H - 1)) == 11'(BRICK_H - 1));
    assign pixel_next = in_field && !on_gap && alive[pix_idx];
    assign row_next   = in_field ? pix_row[2:0] : 3'd0;

    // Overlap of the ball box with the full pitch rectangle, both edges inclusive.
    // Signed arithmetic keeps a ball near the origin from wrapping to a huge x/y.
    logic signed [11:0] ball_x, ball_y, brick_x, brick_y;
    logic               overlap, scan_hit, scan_last;

    assign ball_x    = $signed({2'b00, ball_x_q});
    assign ball_y    = $signed({2'b00, ball_y_q});
    assign brick_x   = 12'(LEFT_X) + (12'(scan_col) << SHIFT_X);
    assign brick_y   = 12'(TOP_Y)  + (12'(scan_row) << SHIFT_Y);
    assign overlap   = (ball_x - RAD <= brick_x + PITCH_W) && (ball_x + RAD >= brick_x) &&
                       (ball_y - RAD <= brick_y + PITCH_H) && (ball_y + RAD >= brick_y);
    assign scan_hit  = alive[scan_idx] && overlap;
    assign scan_last = (scan_idx == IDX_W'(NUM - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            alive       <= ALL_ALIVE;
            bricks_left <= FULL_COUNT;
            state       <= IDLE;
            scan_idx    <= '0;
            scan_col    <= '0;
            scan_row    <= '0;
            ball_x_q    <= '0;
            ball_y_q    <= '0;
            brick_pixel <= 1'b0;
            brick_row   <= 3'd0;
            hit_brick   <= 1'b0;
            bounce_y    <= 1'b0;
            cleared     <= 1'b0;
        end else begin
            brick_pixel <= pixel_next;
            brick_row   <= row_next;
            hit_brick   <= 1'b0;
            bounce_y    <= 1'b0;

            // Refill overrides everything, including a brick being cleared this cycle.
            if (refill) begin
                alive       <= ALL_ALIVE;
                bricks_left <= FULL_COUNT;
                state       <= IDLE;
                cleared     <= 1'b0;
            end else begin
                cleared <= (bricks_left == 8'd0);
                case (state)
                    IDLE: begin
                        if (frame_tick) begin
                            ball_x_q <= x_ball;
                            ball_y_q <= y_ball;
                            scan_idx <= '0;
                            scan_col <= '0;
                            scan_row <= '0;
                            state    <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (scan_hit) begin
                            alive[scan_idx] <= 1'b0;
                            bricks_left     <= bricks_left - 8'd1;
                            hit_brick       <= 1'b1;
                            bounce_y        <= 1'b1;
                            state           <= DONE;
                        end else if (scan_last) begin
                            state <= DONE;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                            if (scan_col == 5'(COLS - 1)) begin
                                scan_col <= '0;
                                scan_row <= scan_row + 4'd1;
                            end else begin
                                scan_col <= scan_col + 5'd1;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
